// File: rtl/div_iterate_if.sv
// Operand/result bundle for the iterative signed fixed-point divider.
// master issues start/A/B; slave (the divider) returns busy/done/Q/ovf/dz.
interface div_iterate_if #(
    parameter int NBITS = 16
);
    logic                    start;
    logic signed [NBITS-1:0] A;
    logic signed [NBITS-1:0] B;
    logic                    busy;
    logic                    done;
    logic signed [NBITS-1:0] Q;
    logic                    ovf;
    logic                    dz;

    modport master (output start, A, B, input busy, done, Q, ovf, dz);
    modport slave  (input start, A, B, output busy, done, Q, ovf, dz);
endinterface

// File: rtl/div_iterate.sv
// Radix-2 restoring divider: Q = (A << QUANT) / B, signed, saturating, one quotient bit per cycle.
// Latency: done is high in the 27th cycle after the start edge (NBITS=16, QUANT=8); start ignored unless idle.
module div_iterate #(
    parameter int NBITS = 16,
    parameter int QUANT = 8
) (
    input  logic          clk,
    input  logic          reset,
    div_iterate_if.slave  io
);
    localparam int QW = NBITS + QUANT;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(QW);
    localparam logic [NBITS-1:0] Q_MAX    = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] Q_MIN    = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [QW-1:0]    MAG_POS  = QW'(Q_MAX);
    localparam logic [QW-1:0]    MAG_NEG  = QW'(Q_MIN);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state_q;
    logic [NBITS-1:0] a_q, b_q, babs_q;
    logic [QW-1:0]    dvd_q, quo_q;
    logic [NBITS:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             sign_q, sign_a_q, dz_in_q;
    logic [NBITS-1:0] q_q;
    logic             ovf_q, dz_q, busy_q, done_q;

    logic [NBITS-1:0] a_abs, b_abs, mag_lo, q_d;
    logic [NBITS:0]   rem_sh, rem_d;
    logic             take, ovf_d;

    always_comb begin
        a_abs  = a_q[NBITS-1] ? (~a_q + 1'b1) : a_q;
        b_abs  = b_q[NBITS-1] ? (~b_q + 1'b1) : b_q;
        rem_sh = (NBITS+1)'({rem_q, dvd_q[QW-1]});
        take   = rem_sh >= {1'b0, babs_q};
        rem_d  = take ? (rem_sh - {1'b0, babs_q}) : rem_sh;
    end

    // Saturation uses the full-width magnitude; the low bits are the in-range result.
    always_comb begin
        mag_lo = quo_q[NBITS-1:0];
        q_d    = sign_q ? (~mag_lo + 1'b1) : mag_lo;
        ovf_d  = 1'b0;
        if (dz_in_q) begin
            q_d   = sign_a_q ? Q_MIN : Q_MAX;
            ovf_d = 1'b1;
        end else if (!sign_q && (quo_q > MAG_POS)) begin
            q_d   = Q_MAX;
            ovf_d = 1'b1;
        end else if (sign_q && (quo_q > MAG_NEG)) begin
            q_d   = Q_MIN;
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            babs_q   <= '0;
            dvd_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            sign_a_q <= 1'b0;
            dz_in_q  <= 1'b0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.start) begin
                        a_q      <= io.A;
                        b_q      <= io.B;
                        sign_q   <= io.A[NBITS-1] ^ io.B[NBITS-1];
                        sign_a_q <= io.A[NBITS-1];
                        dz_in_q  <= (io.B == '0);
                        rem_q    <= '0;
                        quo_q    <= '0;
                        cnt_q    <= CNT_LOAD;
                        busy_q   <= 1'b1;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    // First ITER cycle takes magnitudes, keeping negation off the input path.
                    if (cnt_q == CNT_LOAD) begin
                        dvd_q  <= QW'(a_abs) << QUANT;
                        babs_q <= b_abs;
                        cnt_q  <= cnt_q - 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= {quo_q[QW-2:0], take};
                        dvd_q <= {dvd_q[QW-2:0], 1'b0};
                        if (cnt_q == '0) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                FIX: begin
                    q_q     <= q_d;
                    ovf_q   <= ovf_d;
                    dz_q    <= dz_in_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.Q    = q_q;
    assign io.ovf  = ovf_q;
    assign io.dz   = dz_q;
endmodule

// File: tb/tb_div_iterate.sv
// Bench for div_iterate: cycle-level expectation model plus directed literal cases.
// Random start traffic, including starts while busy, is checked against plain integer division.
module tb_div_iterate;
    localparam int NBITS = 16;
    localparam int QUANT = 8;
    localparam int LAT   = 27;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    div_iterate_if #(.NBITS(NBITS)) io();

    div_iterate #(.NBITS(NBITS), .QUANT(QUANT)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Reference: exact integer quotient truncated toward zero, then clipped to the signed range.
    function automatic void model(input logic signed [NBITS-1:0] a, input logic signed [NBITS-1:0] b,
                                  output logic signed [NBITS-1:0] q, output bit ovf, output bit dz);
        longint num, r;
        dz = (b == 0);
        if (dz) begin
            q   = (a < 0) ? -16'sd32768 : 16'sd32767;
            ovf = 1'b1;
        end else begin
            num = longint'(a) * (longint'(1) << QUANT);
            r   = num / longint'(b);
            if (r > 32767) begin
                q = 16'sd32767; ovf = 1'b1;
            end else if (r < -32768) begin
                q = -16'sd32768; ovf = 1'b1;
            end else begin
                q = r[NBITS-1:0]; ovf = 1'b0;
            end
        end
    endfunction

    // ph: 0 idle, 1..LAT-1 busy cycles, LAT the done cycle.
    int                      ph = 0;
    logic signed [NBITS-1:0] pend_q, held_q;
    bit                      pend_ovf, pend_dz, held_ovf, held_dz;
    bit                      eb, ed;

    initial begin
        held_q = '0; held_ovf = 1'b0; held_dz = 1'b0;
        pend_q = '0; pend_ovf = 1'b0; pend_dz = 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            ph = 0;
            held_q = '0; held_ovf = 1'b0; held_dz = 1'b0;
            chk("rst_busy", io.busy, 0);
            chk("rst_done", io.done, 0);
            chk("rst_Q", io.Q, 0);
            chk("rst_ovf", io.ovf, 0);
            chk("rst_dz", io.dz, 0);
        end else begin
            eb = (ph >= 1) && (ph < LAT);
            ed = (ph == LAT);
            if (ed) begin
                held_q = pend_q; held_ovf = pend_ovf; held_dz = pend_dz;
            end
            chk("busy", io.busy, eb);
            chk("done", io.done, ed);
            chk("Q", io.Q, held_q);
            chk("ovf", io.ovf, held_ovf);
            chk("dz", io.dz, held_dz);
            if (ph == 0) begin
                if (io.start) begin
                    model(io.A, io.B, pend_q, pend_ovf, pend_dz);
                    ph = 1;
                end
            end else if (ph == LAT) begin
                ph = 0;
            end else begin
                ph++;
            end
        end
    end

    task automatic issue(input logic signed [NBITS-1:0] a, input logic signed [NBITS-1:0] b);
        @(posedge clk); #1;
        io.start = 1'b1; io.A = a; io.B = b;
        @(posedge clk); #1;
        io.start = 1'b0;
    endtask

    // Waits for done after an issue; optionally re-pulses start with junk operands at cycles p1/p2.
    task automatic wait_done(input string nm, input logic signed [NBITS-1:0] eq, input bit eo, input bit ez,
                             input int p1, input int p2);
        int  c;
        bit  seen;
        seen = 1'b0;
        c = 0;
        while (!seen && c < 60) begin
            @(negedge clk);
            c++;
            if (io.done) begin
                seen = 1'b1;
            end else if (c == p1 || c == p2) begin
                #2;
                io.start = 1'b1;
                io.A = 16'($urandom);
                io.B = 16'($urandom);
            end else if (io.start) begin
                #2;
                io.start = 1'b0;
            end
        end
        io.start = 1'b0;
        if (!seen) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            chk({nm, "_lat"}, c, LAT);
            chk({nm, "_Q"}, io.Q, eq);
            chk({nm, "_ovf"}, io.ovf, eo);
            chk({nm, "_dz"}, io.dz, ez);
        end
    endtask

    task automatic run(input string nm, input logic signed [NBITS-1:0] a, input logic signed [NBITS-1:0] b,
                       input logic signed [NBITS-1:0] eq, input bit eo, input bit ez);
        issue(a, b);
        wait_done(nm, eq, eo, ez, -1, -1);
    endtask

    initial begin
        io.start = 1'b0;
        io.A = '0;
        io.B = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run("basic", 768, 512, 384, 0, 0);
        run("neg_pos", -768, 512, -384, 0, 0);
        run("neg_neg", -768, -512, 384, 0, 0);
        run("third", 1, 3, 85, 0, 0);
        run("mthird", -1, 3, -85, 0, 0);
        run("sat_pos", 32767, 1, 32767, 1, 0);
        run("sat_neg", -32768, 1, -32768, 1, 0);
        run("sat_min", -32768, -256, 32767, 1, 0);
        run("dz_neg", -5, 0, -32768, 1, 1);
        run("dz_pos", 5, 0, 32767, 1, 1);
        run("dz_zero", 0, 0, 32767, 1, 1);

        issue(768, 512);
        wait_done("ignore", 384, 0, 0, 5, 20);
        run("b2b", -768, -512, 384, 0, 0);

        issue(768, 512);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", io.busy, 0);
        chk("abort_Q", io.Q, 0);
        run("after_rst", 512, 256, 512, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            io.start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       io.A = 16'($urandom_range(0, 1200)) - 16'sd600;
                default: io.A = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       io.B = '0;
                1, 2:    io.B = 16'($urandom_range(0, 1200)) - 16'sd600;
                3:       io.B = 16'($urandom_range(0, 600)) - 16'sd300;
                default: io.B = 16'($urandom);
            endcase
        end
        io.start = 1'b0;
        repeat (LAT + 5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
